// File: rtl/audio_seq_pkg.sv
// Shared FSM state type and default widths for the audio stream sequencer.
package audio_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } seqState_e;

   localparam int DEF_SAMPLE_W = 32;
   localparam int DEF_DISP_W   = 16;
   localparam int CHOP_W       = 18;

endpackage

// File: rtl/audio_stream_sequencer_if.sv
// Codec FIFO strobes/samples and display handshake bundled for the sequencer.
interface audio_stream_sequencer_if
   import audio_seq_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int DISP_W   = DEF_DISP_W
) ();

   logic                audio_in_available;
   logic                audio_out_allowed;
   logic [SAMPLE_W-1:0] left_in;
   logic [SAMPLE_W-1:0] right_in;
   logic                read_audio_in;
   logic                write_audio_out;
   logic [SAMPLE_W-1:0] left_out;
   logic [SAMPLE_W-1:0] right_out;
   logic [DISP_W-1:0]   disp_data;
   logic                disp_valid;
   logic                disp_ready;

   modport master (
      input  audio_in_available, audio_out_allowed, left_in, right_in, disp_ready,
      output read_audio_in, write_audio_out, left_out, right_out, disp_data, disp_valid
   );

   modport slave (
      output audio_in_available, audio_out_allowed, left_in, right_in, disp_ready,
      input  read_audio_in, write_audio_out, left_out, right_out, disp_data, disp_valid
   );

endinterface

// File: rtl/audio_stream_sequencer_chop_gen.sv
// Chopper gate: toggles every period+1 clocks; period 0 holds the gate open.
module chop_gen
   import audio_seq_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic [CHOP_W-1:0] period,
   output logic              gate
);

   logic [CHOP_W-1:0] count_q, count_d;
   logic              gate_q, gate_d;

   // A period lowered below the running count clears on the next edge instead of wrapping.
   always_comb begin
      count_d = count_q + 1'b1;
      gate_d  = gate_q;
      if (period == '0) begin
         count_d = '0;
         gate_d  = 1'b0;
      end else if (count_q >= period) begin
         count_d = '0;
         gate_d  = ~gate_q;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         gate_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gate_q  <= gate_d;
      end
   end

   assign gate = gate_q;

endmodule

// File: rtl/audio_stream_sequencer.sv
// Moves one codec sample per IDLE->READ->WRITE pass, decimates to a display stream.
// Chopper muting is built only when AUDIO_SEQ_CHOPPER_EN is defined.
module audio_stream_sequencer
   import audio_seq_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int DISP_W   = DEF_DISP_W,
   parameter int DECIM    = 256
) (
   input  logic                       CLOCK_50,
   input  logic                       resetn,
   input  logic [CHOP_W-1:0]          chop_period,
   audio_stream_sequencer_if.master   bus,
   output logic                       disp_overrun,
   output logic [15:0]                level,
   output logic                       chop_state
);

   localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);

   seqState_e           state_q, state_d;
   logic [SAMPLE_W-1:0] leftOut_q, leftOut_d;
   logic [SAMPLE_W-1:0] rightOut_q, rightOut_d;
   logic [15:0]         level_q, level_d;
   logic [15:0]         decCnt_q, decCnt_d;
   logic [DISP_W-1:0]   dispData_q, dispData_d;
   logic                dispValid_q, dispValid_d;
   logic                overrun_q, overrun_d;
   logic                chopGate;
   logic                take;
   logic                newSample;

`ifdef AUDIO_SEQ_CHOPPER_EN
   chop_gen u_chop (
      .clock  (CLOCK_50),
      .resetn (resetn),
      .period (chop_period),
      .gate   (chopGate)
   );
`else
   logic unusedChopPeriod;
   assign unusedChopPeriod = ^chop_period;
   assign chopGate         = 1'b0;
`endif

   assign take      = (state_q == IDLE) && bus.audio_in_available && bus.audio_out_allowed;
   assign newSample = (state_q == WRITE) && (decCnt_q == DECIM_LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (take) state_d = READ;
         READ:    state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Display side never back-pressures audio: a sample arriving while one is still unaccepted is dropped.
   always_comb begin
      leftOut_d   = leftOut_q;
      rightOut_d  = rightOut_q;
      level_d     = level_q;
      decCnt_d    = decCnt_q;
      dispData_d  = dispData_q;
      dispValid_d = dispValid_q;
      overrun_d   = overrun_q;
      if (take) begin
         leftOut_d  = chopGate ? '0 : bus.left_in;
         rightOut_d = chopGate ? '0 : bus.right_in;
      end
      if (state_q == READ) begin
         level_d = leftOut_q[SAMPLE_W-1 -: 16];
      end
      if (state_q == WRITE) begin
         decCnt_d = newSample ? '0 : decCnt_q + 1'b1;
      end
      if (newSample && (!dispValid_q || bus.disp_ready)) begin
         dispData_d  = rightOut_q[SAMPLE_W-1 -: DISP_W];
         dispValid_d = 1'b1;
      end else if (newSample) begin
         overrun_d = 1'b1;
      end else if (dispValid_q && bus.disp_ready) begin
         dispValid_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         leftOut_q   <= '0;
         rightOut_q  <= '0;
         level_q     <= '0;
         decCnt_q    <= '0;
         dispData_q  <= '0;
         dispValid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         leftOut_q   <= leftOut_d;
         rightOut_q  <= rightOut_d;
         level_q     <= level_d;
         decCnt_q    <= decCnt_d;
         dispData_q  <= dispData_d;
         dispValid_q <= dispValid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.read_audio_in   = (state_q == READ);
   assign bus.write_audio_out = (state_q == WRITE);
   assign bus.left_out        = leftOut_q;
   assign bus.right_out       = rightOut_q;
   assign bus.disp_data       = dispData_q;
   assign bus.disp_valid      = dispValid_q;
   assign disp_overrun        = overrun_q;
   assign level               = level_q;
   assign chop_state          = chopGate;

endmodule
